// File: rtl/serdes_align_pkg.sv
// Shared types, default constants and width helpers for the SERDES word-alignment checker.
package serdes_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VERIFY = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4
    } state_e;

    localparam int DEF_MATCH_COUNT = 16;
    localparam int DEF_SLIP_WAIT   = 3;
    localparam int DEF_LOSS_THRESH = 4;

    // Width of the slip counter: enough to count 0..DATA_WIDTH-1, never less than one bit.
    function automatic int slip_cnt_width(input int dw);
        if ($clog2(dw) < 1) begin
            return 1;
        end else begin
            return $clog2(dw);
        end
    endfunction

endpackage

// File: rtl/serdes_align_checker_if.sv
// Data/status bundle between the ISERDES side and the alignment checker.
interface serdes_align_checker_if
    import serdes_align_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ERR_WIDTH  = 8
);
    localparam int SC_W = slip_cnt_width(DATA_WIDTH);

    logic                  enable;
    logic [DATA_WIDTH-1:0] data;
    logic                  bitslip;
    logic                  locked;
    logic                  fail;
    logic [SC_W-1:0]       slip_cnt;
    logic [ERR_WIDTH-1:0]  err_cnt;

    // Source side: drives run control and ISERDES words, observes status.
    modport master (
        output enable, data,
        input  bitslip, locked, fail, slip_cnt, err_cnt
    );

    // Checker side.
    modport slave (
        input  enable, data,
        output bitslip, locked, fail, slip_cnt, err_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // Count up on inc, stop at MAX, synchronous clear has priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/serdes_align_checker.sv
// Word-alignment and link checker: slips the ISERDES until the training word lines up,
// declares lock after a run of matches, then counts errors and drops lock on an error burst.
module serdes_align_checker
    import serdes_align_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 2,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(2'b01),
    parameter int                    MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int                    SLIP_WAIT     = DEF_SLIP_WAIT,
    parameter int                    LOSS_THRESH   = DEF_LOSS_THRESH,
    parameter int                    ERR_WIDTH     = 8
) (
    input  logic                  clkdiv_i,
    input  logic                  rst_n_i,
    serdes_align_checker_if.slave bus
);

    localparam int SC_W   = slip_cnt_width(DATA_WIDTH);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int LOSS_W = $clog2(LOSS_THRESH + 1);
    localparam int ATT_W  = $clog2(2 * DATA_WIDTH + 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [7:0]            match_q;
    logic [WAIT_W-1:0]     wait_q;
    logic [LOSS_W-1:0]     miss_q;
    logic                  bitslip_q;
    logic                  locked_q;
    logic                  fail_q;
    logic [SC_W-1:0]       slip_cnt_q;

    logic                  match_s;
    logic                  err_inc_s;
    logic                  att_inc_s;
    logic                  att_clr_s;
    logic                  lock_loss_s;
    logic [ATT_W-1:0]      attempt_cnt_s;
    logic [ERR_WIDTH-1:0]  err_cnt_s;

    assign match_s     = (data_q == TRAIN_PATTERN);
    assign err_inc_s   = bus.enable && (state_q == ST_LOCKED) && !match_s;
    assign lock_loss_s = err_inc_s && (miss_q == LOSS_W'(LOSS_THRESH - 1));
    assign att_inc_s   = bus.enable && (state_q == ST_VERIFY) && !match_s;
    assign att_clr_s   = !bus.enable || lock_loss_s;

    sat_counter #(
        .WIDTH (ERR_WIDTH),
        .MAX   ({ERR_WIDTH{1'b1}})
    ) u_err_cnt (
        .clk_i   (clkdiv_i),
        .rst_n_i (rst_n_i),
        .clr_i   (!bus.enable),
        .inc_i   (err_inc_s),
        .cnt_o   (err_cnt_s)
    );

    sat_counter #(
        .WIDTH (ATT_W),
        .MAX   (ATT_W'(2 * DATA_WIDTH))
    ) u_attempt_cnt (
        .clk_i   (clkdiv_i),
        .rst_n_i (rst_n_i),
        .clr_i   (att_clr_s),
        .inc_i   (att_inc_s),
        .cnt_o   (attempt_cnt_s)
    );

    // Input register: every comparison looks at the word captured one edge earlier.
    always_ff @(posedge clkdiv_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else begin
            data_q <= bus.data;
        end
    end

    // Alignment FSM with its counters and registered status outputs.
    always_ff @(posedge clkdiv_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            match_q    <= 8'd0;
            wait_q     <= '0;
            miss_q     <= '0;
            bitslip_q  <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            slip_cnt_q <= '0;
        end else if (!bus.enable) begin
            // Disable wins everywhere, so a pending slip is simply dropped.
            state_q    <= ST_IDLE;
            match_q    <= 8'd0;
            wait_q     <= '0;
            miss_q     <= '0;
            bitslip_q  <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_VERIFY;
                    match_q <= 8'd0;
                end
                ST_VERIFY: begin
                    if (match_s) begin
                        if (match_q == 8'(MATCH_COUNT - 1)) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            miss_q   <= '0;
                        end else begin
                            match_q <= match_q + 8'd1;
                        end
                    end else begin
                        // The pulse is registered here so it is high during the SLIP cycle.
                        state_q   <= ST_SLIP;
                        bitslip_q <= 1'b1;
                        if (slip_cnt_q == SC_W'(DATA_WIDTH - 1)) begin
                            slip_cnt_q <= '0;
                        end else begin
                            slip_cnt_q <= slip_cnt_q + SC_W'(1);
                        end
                        if (attempt_cnt_s >= ATT_W'(2 * DATA_WIDTH - 1)) begin
                            fail_q <= 1'b1;
                        end else begin
                            fail_q <= fail_q;
                        end
                    end
                end
                ST_SLIP: begin
                    state_q <= ST_WAIT;
                    wait_q  <= '0;
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_q <= ST_VERIFY;
                        match_q <= 8'd0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        miss_q <= '0;
                    end else if (lock_loss_s) begin
                        state_q  <= ST_VERIFY;
                        locked_q <= 1'b0;
                        match_q  <= 8'd0;
                        miss_q   <= '0;
                    end else begin
                        miss_q <= miss_q + LOSS_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bitslip  = bitslip_q;
    assign bus.locked   = locked_q;
    assign bus.fail     = fail_q;
    assign bus.slip_cnt = slip_cnt_q;
    assign bus.err_cnt  = err_cnt_s;

endmodule

// File: tb/tb_serdes_align_checker.sv
// Directed bench for serdes_align_checker: ISERDES model rotates the word per BITSLIP.
module tb_serdes_align_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] base;
    int         rot;
    logic [1:0] slip_pipe;

    always #5 clk = ~clk;

    serdes_align_checker_if #(.DATA_WIDTH(2), .ERR_WIDTH(8)) bus   ();
    serdes_align_checker_if #(.DATA_WIDTH(2), .ERR_WIDTH(4)) bus_s ();

    serdes_align_checker #(.DATA_WIDTH(2), .ERR_WIDTH(8)) dut (
        .clkdiv_i (clk),
        .rst_n_i  (rst_n),
        .bus      (bus)
    );

    serdes_align_checker #(.DATA_WIDTH(2), .ERR_WIDTH(4)) dut_s (
        .clkdiv_i (clk),
        .rst_n_i  (rst_n),
        .bus      (bus_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rotl(input logic [1:0] w, input int r);
        return (r % 2 == 1) ? {w[0], w[1]} : w;
    endfunction

    task automatic set_base(input logic [1:0] b);
        base     = b;
        bus.data = rotl(base, rot);
    endtask

    // Advance to the next falling edge; the ISERDES model applies a slip one cycle after seeing it.
    task automatic tick();
        @(negedge clk);
        slip_pipe = {slip_pipe[0], bus.bitslip};
        if (slip_pipe[1]) rot = rot + 1;
        bus.data = rotl(base, rot);
    endtask

    task automatic model_reset();
        rot       = 0;
        slip_pipe = 2'b00;
    endtask

    initial begin
        int any_slip, pulses, dbl, lock_at, np;
        logic prev;
        int   pulse_at [8];
        logic sc_at    [8];

        bus.enable   = 1'b0;
        bus.data     = 2'b00;
        bus_s.enable = 1'b0;
        bus_s.data   = 2'b00;
        base         = 2'b00;
        model_reset();

        // Reset state
        repeat (3) tick();
        check_eq("rst_bitslip",  32'(bus.bitslip),  32'd0);
        check_eq("rst_locked",   32'(bus.locked),   32'd0);
        check_eq("rst_fail",     32'(bus.fail),     32'd0);
        check_eq("rst_slip_cnt", 32'(bus.slip_cnt), 32'd0);
        check_eq("rst_err_cnt",  32'(bus.err_cnt),  32'd0);
        rst_n = 1'b1;
        tick();

        // Aligned input: lock at the 17th enabled edge, no slips
        set_base(2'b01);
        bus.enable = 1'b1;
        any_slip   = 0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (bus.bitslip) any_slip = 1;
            if (k == 16) check_eq("aligned_lock_at16", 32'(bus.locked), 32'd0);
        end
        check_eq("aligned_lock_at17", 32'(bus.locked),   32'd1);
        check_eq("aligned_no_slip",   32'(any_slip),     32'd0);
        check_eq("aligned_slip_cnt",  32'(bus.slip_cnt), 32'd0);

        // Errors while locked: 3 bad words keep lock
        set_base(2'b00);
        repeat (3) tick();
        set_base(2'b01);
        repeat (3) tick();
        check_eq("err3_locked",  32'(bus.locked),  32'd1);
        check_eq("err3_err_cnt", 32'(bus.err_cnt), 32'd3);

        // 4 consecutive bad words drop lock, then a slip follows
        set_base(2'b00);
        repeat (4) tick();
        check_eq("loss_still_locked", 32'(bus.locked), 32'd1);
        tick();
        check_eq("loss_locked",  32'(bus.locked),  32'd0);
        check_eq("loss_err_cnt", 32'(bus.err_cnt), 32'd7);
        tick();
        check_eq("loss_bitslip", 32'(bus.bitslip), 32'd1);
        check_eq("loss_err_hold", 32'(bus.err_cnt), 32'd7);

        // Disable clears status
        bus.enable = 1'b0;
        tick();
        check_eq("dis_err_cnt", 32'(bus.err_cnt), 32'd0);
        check_eq("dis_locked",  32'(bus.locked),  32'd0);

        // One-off misalignment: single slip, lock at edge 22
        model_reset();
        set_base(2'b10);
        bus.enable = 1'b1;
        pulses = 0; dbl = 0; lock_at = 0; prev = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.bitslip) pulses++;
            if (bus.bitslip && prev) dbl = 1;
            prev = bus.bitslip;
            if (bus.locked && lock_at == 0) lock_at = k;
        end
        check_eq("mis_pulses",   32'(pulses),       32'd1);
        check_eq("mis_slip_cnt", 32'(bus.slip_cnt), 32'd1);
        check_eq("mis_lock_at",  32'(lock_at),      32'd22);
        check_eq("mis_fail",     32'(bus.fail),     32'd0);
        check_eq("mis_no_dbl",   32'(dbl),          32'd0);

        // Persistent mismatch: slip every 5 cycles, FAIL on the 4th pulse
        bus.enable = 1'b0;
        tick();
        model_reset();
        set_base(2'b00);
        bus.enable = 1'b1;
        np = 0; dbl = 0; prev = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.bitslip && np < 8) begin
                pulse_at[np] = k;
                sc_at[np]    = bus.slip_cnt[0];
                np++;
            end
            if (bus.bitslip && prev) dbl = 1;
            prev = bus.bitslip;
            if (k == 16) check_eq("pers_fail_pre", 32'(bus.fail), 32'd0);
            if (k == 17) check_eq("pers_fail_set", 32'(bus.fail), 32'd1);
        end
        check_eq("pers_num_pulses", 32'(np), 32'd6);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("pers_pulse%0d_at", i), 32'(pulse_at[i]), 32'(2 + 5 * i));
            check_eq($sformatf("pers_pulse%0d_sc", i), 32'(sc_at[i]),    32'((i + 1) % 2));
        end
        check_eq("pers_fail_hold", 32'(bus.fail), 32'd1);
        check_eq("pers_no_dbl",    32'(dbl),      32'd0);

        // FAIL stays set through a later lock
        set_base(2'b01);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.locked) break;
        end
        check_eq("relock_locked", 32'(bus.locked), 32'd1);
        check_eq("relock_fail",   32'(bus.fail),   32'd1);
        set_base(2'b00);
        tick();
        set_base(2'b01);
        repeat (3) tick();
        check_eq("relock_err_cnt", 32'(bus.err_cnt), 32'd1);
        check_eq("relock_hold",    32'(bus.locked),  32'd1);

        // ENABLE low while locked clears everything on the next edge
        bus.enable = 1'b0;
        tick();
        check_eq("disl_locked",   32'(bus.locked),   32'd0);
        check_eq("disl_err_cnt",  32'(bus.err_cnt),  32'd0);
        check_eq("disl_fail",     32'(bus.fail),     32'd0);
        check_eq("disl_slip_cnt", 32'(bus.slip_cnt), 32'd0);

        // Reset asserted mid-WAIT
        model_reset();
        set_base(2'b00);
        bus.enable = 1'b1;
        repeat (3) tick();
        check_eq("rstw_slip_cnt_pre", 32'(bus.slip_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstw_bitslip",  32'(bus.bitslip),  32'd0);
        check_eq("rstw_locked",   32'(bus.locked),   32'd0);
        check_eq("rstw_fail",     32'(bus.fail),     32'd0);
        check_eq("rstw_slip_cnt", 32'(bus.slip_cnt), 32'd0);
        check_eq("rstw_err_cnt",  32'(bus.err_cnt),  32'd0);
        any_slip = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.bitslip) any_slip = 1;
        end
        check_eq("rstw_no_slip", 32'(any_slip), 32'd0);
        bus.enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Saturation with a 4-bit error counter
        bus_s.data   = 2'b01;
        bus_s.enable = 1'b1;
        repeat (17) tick();
        check_eq("sat_locked_pre", 32'(bus_s.locked), 32'd1);
        for (int i = 0; i < 20; i++) begin
            bus_s.data = 2'b00;
            tick();
            bus_s.data = 2'b01;
            tick();
        end
        repeat (2) tick();
        check_eq("sat_err_cnt", 32'(bus_s.err_cnt), 32'd15);
        check_eq("sat_locked",  32'(bus_s.locked),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_align_checker.md
# serdes_align_checker

Word-alignment and link checker for the CLKDIV domain, directly downstream of an ISERDES parallel output in the SERDES loopback tests. It searches for a fixed training word, issues BITSLIP pulses back to the ISERDES until the word is aligned, and declares lock after a run of matches. Once locked it counts mismatching words and drops lock on a burst of consecutive errors; LOCKED/FAIL/ERR_CNT feed the board LEDs.

## Interface
- DATA_WIDTH, 2: ISERDES word width, 2..8.
- TRAIN_PATTERN, 'b01 (zero-extended): expected aligned word; all its rotations must differ.
- MATCH_COUNT, 16: consecutive matches required to lock, 1..255.
- SLIP_WAIT, 3: cycles ignored after a BITSLIP pulse (ISERDES latency plus input register), ≥1.
- LOSS_THRESH, 4: consecutive mismatches while locked that drop lock, ≥1.
- ERR_WIDTH, 8: width of the error counter.
- CLKDIV  in  1  word clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run; low forces IDLE and clears status.
- DATA  in  DATA_WIDTH  ISERDES Q word, valid every cycle.
- BITSLIP  out  1  single-cycle slip request to the ISERDES.
- LOCKED  out  1  alignment achieved and held.
- FAIL  out  1  sticky: 2*DATA_WIDTH slips without lock.
- SLIP_CNT  out  max(1,$clog2(DATA_WIDTH))  slips issued modulo DATA_WIDTH.
- ERR_CNT  out  ERR_WIDTH  saturating count of mismatches while LOCKED.

## Operation
- DATA is registered once (data_q); every comparison uses data_q == TRAIN_PATTERN.
- States: IDLE, VERIFY, SLIP, WAIT, LOCKED.
- IDLE: all outputs and counters 0. ENABLE high → VERIFY, match counter 0.
- VERIFY: match → match counter +1; when it reaches MATCH_COUNT → LOCKED. Mismatch → SLIP.
- SLIP: BITSLIP=1 for exactly this one cycle; SLIP_CNT increments and wraps DATA_WIDTH-1 → 0; attempt counter increments and saturates at 2*DATA_WIDTH; → WAIT with wait counter 0.
- WAIT: data_q ignored for SLIP_WAIT cycles, then → VERIFY with match counter 0.
- FAIL sets once the attempt counter reaches 2*DATA_WIDTH; slipping continues. FAIL clears only in IDLE or on reset, including after a later lock.
- LOCKED: mismatch → ERR_CNT +1, saturating at all-ones, and consecutive-miss counter +1. Match → consecutive-miss counter 0.
- Consecutive-miss counter reaching LOSS_THRESH → LOCKED=0, → VERIFY with match counter 0.
- On loss of lock: ERR_CNT holds; the attempt counter resets to 0.
- ENABLE low in any state: → IDLE on the next edge; a pending BITSLIP is not issued.
- Reset values: BITSLIP 0, LOCKED 0, FAIL 0, SLIP_CNT 0, ERR_CNT 0, state IDLE, data_q 0.

## Timing
- DATA sampled at edge n is compared at edge n+1. Resulting state, counter and output updates are visible after edge n+1; all outputs are registered.
- Lock latency with aligned input: LOCKED rises at the (MATCH_COUNT+1)-th edge at which ENABLE is sampled high.
- Slip cadence with persistent mismatch: 1 SLIP + SLIP_WAIT WAIT + 1 VERIFY cycles, so one BITSLIP every 5 cycles at defaults.
- BITSLIP is never high on two consecutive cycles.
- RST_N low clears everything asynchronously; release is synchronised externally.
- ENABLE and the reset-release edge coinciding: ENABLE is honoured from the following edge.

## Structure
- Package serdes_align_pkg holds:
  - the state enum;
  - default constants for MATCH_COUNT, SLIP_WAIT and LOSS_THRESH;
  - a function returning the SLIP_CNT width.
- Sub-module sat_counter (parameterised width, inc, clr, async active-low reset) is used for ERR_CNT and the attempt counter.

## Test plan
All scenarios use defaults unless stated; the bench ISERDES model rotates one bit per BITSLIP with 2-cycle latency.
- Aligned input: ENABLE=1, DATA=2'b01 constant → LOCKED rises at the 17th edge with ENABLE high; BITSLIP never pulses; SLIP_CNT=0.
- One-off misalignment: stream starts as 2'b10 → exactly one BITSLIP pulse; SLIP_CNT=1; LOCKED after 16 matches; FAIL=0.
- Persistent mismatch: DATA=2'b00 → BITSLIP every 5 cycles; SLIP_CNT toggles 1,0,1,0; FAIL rises on the edge of the 4th pulse and stays high.
- Errors while locked:
  - 3 bad words then good → LOCKED stays high, ERR_CNT=3.
  - Then 4 consecutive bad words → LOCKED falls at the 4th, ERR_CNT=7, BITSLIP on the next cycle.
- Saturation: ERR_WIDTH=4, 20 isolated bad words while locked → ERR_CNT=15, LOCKED stays high.
- Reset and disable:
  - RST_N low mid-WAIT → all outputs 0 immediately, no BITSLIP afterwards.
  - ENABLE low while LOCKED → next edge LOCKED=0, ERR_CNT=0, FAIL=0.
